// File: rtl/vga_sync_decoder_if.sv
// Sync-pair input and recovered timing outputs of the VGA sync decoder.
// master drives the sync pair (source side); slave is the decoder.
interface vga_sync_decoder_if;
    logic        h_synch;
    logic        v_synch;
    logic [10:0] pixel_x;
    logic [9:0]  line_y;
    logic        de;
    logic        frame_start;
    logic        locked;
    logic        sync_error;
    logic [10:0] h_period;
    logic [9:0]  v_period;

    modport master (
        output h_synch, v_synch,
        input  pixel_x, line_y, de, frame_start, locked, sync_error, h_period, v_period
    );

    modport slave (
        input  h_synch, v_synch,
        output pixel_x, line_y, de, frame_start, locked, sync_error, h_period, v_period
    );
endinterface

// File: rtl/vga_sync_decoder.sv
// Recovers pixel/line coordinates from an active-low VGA sync pair and
// verifies the measured timing against the configured mode (lock/error).
module vga_sync_decoder #(
    parameter int unsigned WIDTH       = 640,
    parameter int unsigned H_FP        = 16,
    parameter int unsigned H_SYNC      = 96,
    parameter int unsigned H_BP        = 48,
    parameter int unsigned HEIGHT      = 480,
    parameter int unsigned V_FP        = 10,
    parameter int unsigned V_SYNC      = 2,
    parameter int unsigned V_BP        = 33,
    parameter int unsigned LOCK_FRAMES = 2
) (
    input  logic              Clock_25,
    input  logic              Reset,
    vga_sync_decoder_if.slave vid
);

    localparam int unsigned H_TOTAL = WIDTH + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = HEIGHT + V_FP + V_SYNC + V_BP;

    localparam logic [1:0] SEARCH  = 2'd0;
    localparam logic [1:0] MEASURE = 2'd1;
    localparam logic [1:0] LOCKED  = 2'd2;

    localparam logic [10:0] PX_LAST   = 11'(H_TOTAL - 1);
    localparam logic [10:0] PX_HALIGN = 11'(WIDTH + H_FP + 1);
    localparam logic [9:0]  LY_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0]  LY_VALIGN = 10'(HEIGHT + V_FP);
    localparam logic [11:0] H_TOT_C   = 12'(H_TOTAL);
    localparam logic [11:0] H_LOSS    = 12'(2 * H_TOTAL);
    localparam logic [10:0] H_SYNC_C  = 11'(H_SYNC);
    localparam logic [9:0]  V_TOT_C   = 10'(V_TOTAL);
    localparam logic [9:0]  V_SYNC_C  = 10'(V_SYNC);
    localparam logic [10:0] WIDTH_C   = 11'(WIDTH);
    localparam logic [9:0]  HEIGHT_C  = 10'(HEIGHT);
    localparam logic [7:0]  GOOD_LAST = 8'(LOCK_FRAMES - 1);

    logic        h_prev, v_prev;
    logic        h_fall, h_rise, v_fall, v_rise;
    logic        wrap;
    logic [1:0]  state;
    logic [10:0] pixel_x, h_period;
    logic [9:0]  line_y, v_period;
    logic [11:0] h_cnt, h_cnt_inc;
    logic [10:0] h_low;
    logic [9:0]  v_cnt, v_low;
    logic        h_armed;
    logic [7:0]  good_cnt;
    logic        sync_error;
    logic        h_bad, v_bad, loss, fail;

    always_comb begin
        h_fall    = h_prev & ~vid.h_synch;
        h_rise    = ~h_prev & vid.h_synch;
        v_fall    = v_prev & ~vid.v_synch;
        v_rise    = ~v_prev & vid.v_synch;
        wrap      = (pixel_x == PX_LAST) & ~h_fall;
        h_cnt_inc = h_cnt + 12'd1;
        // the first h_fall after entering MEASURE only arms the line checks
        h_bad     = h_armed & ((h_fall & (h_cnt_inc != H_TOT_C)) |
                               (h_rise & (h_low != H_SYNC_C)));
        v_bad     = (v_fall & (v_cnt != V_TOT_C)) | (v_rise & (v_low != V_SYNC_C));
        // fires on the edge that would take h_cnt to 2*H_TOTAL
        loss      = (h_cnt == H_LOSS - 12'd1) & ~h_fall;
        fail      = (state != SEARCH) & (h_bad | v_bad | loss);
    end

    always_ff @(posedge Clock_25 or negedge Reset) begin
        if (!Reset) begin
            h_prev     <= 1'b1;
            v_prev     <= 1'b1;
            pixel_x    <= '0;
            line_y     <= '0;
            h_period   <= '0;
            v_period   <= '0;
            h_cnt      <= '0;
            h_low      <= '0;
            v_cnt      <= '0;
            v_low      <= '0;
            h_armed    <= 1'b0;
            good_cnt   <= '0;
            sync_error <= 1'b0;
            state      <= SEARCH;
        end else begin
            h_prev <= vid.h_synch;
            v_prev <= vid.v_synch;

            if (h_fall)
                pixel_x <= PX_HALIGN;
            else if (pixel_x == PX_LAST)
                pixel_x <= '0;
            else
                pixel_x <= pixel_x + 11'd1;

            if (v_fall)
                line_y <= LY_VALIGN;
            else if (wrap)
                line_y <= (line_y == LY_LAST) ? '0 : line_y + 10'd1;

            if (h_fall) begin
                h_period <= h_cnt_inc[11] ? '1 : h_cnt_inc[10:0];
                h_cnt    <= '0;
            end else if ((state == SEARCH) && v_fall) begin
                h_cnt <= '0;
            end else if (h_cnt != H_LOSS) begin
                h_cnt <= h_cnt_inc;
            end

            if (h_fall)
                h_low <= 11'd1;
            else if (!vid.h_synch && (h_low != '1))
                h_low <= h_low + 11'd1;

            if (v_fall) begin
                v_period <= v_cnt;
                v_cnt    <= '0;
            end else if (wrap && (v_cnt != '1)) begin
                v_cnt <= v_cnt + 10'd1;
            end

            if (v_fall)
                v_low <= wrap ? 10'd1 : 10'd0;
            else if (wrap && !vid.v_synch && (v_low != '1))
                v_low <= v_low + 10'd1;

            if (state == SEARCH)
                h_armed <= 1'b0;
            else if (h_fall)
                h_armed <= 1'b1;

            sync_error <= fail;

            case (state)
                SEARCH: begin
                    if (v_fall) begin
                        state    <= MEASURE;
                        good_cnt <= '0;
                    end
                end
                MEASURE: begin
                    if (fail) begin
                        state <= SEARCH;
                    end else if (v_fall) begin
                        if (good_cnt == GOOD_LAST)
                            state <= LOCKED;
                        good_cnt <= good_cnt + 8'd1;
                    end
                end
                LOCKED: begin
                    if (fail)
                        state <= SEARCH;
                end
                default: state <= SEARCH;
            endcase
        end
    end

    assign vid.pixel_x     = pixel_x;
    assign vid.line_y      = line_y;
    assign vid.h_period    = h_period;
    assign vid.v_period    = v_period;
    assign vid.sync_error  = sync_error;
    assign vid.locked      = (state == LOCKED);
    assign vid.de          = (state == LOCKED) && (pixel_x < WIDTH_C) && (line_y < HEIGHT_C);
    assign vid.frame_start = (state == LOCKED) && (pixel_x == '0) && (line_y == '0);

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Directed bench for vga_sync_decoder using a reduced 16x11 video mode.
module tb_vga_sync_decoder;

    localparam int unsigned W = 8, HFP = 2, HSW = 3, HBP = 3;
    localparam int unsigned H = 6, VFP = 1, VSW = 2, VBP = 2;
    localparam int unsigned HT = W + HFP + HSW + HBP;   // 16
    localparam int unsigned VT = H + VFP + VSW + VBP;   // 11
    localparam int unsigned FRAME = HT * VT;            // 176
    localparam int unsigned HS0 = W + HFP, HS1 = HS0 + HSW;
    localparam int unsigned VS0 = H + VFP, VS1 = VS0 + VSW;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int total = 0;
    int bad = 0;

    int unsigned gen_px = 0, gen_ly = 0, htot = HT, cyc = 0;
    logic glitch = 1'b0, hold = 1'b0, vs_last = 1'b1, vfall_now = 1'b0;

    vga_sync_decoder_if vif();

    vga_sync_decoder #(
        .WIDTH(W), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
        .HEIGHT(H), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
        .LOCK_FRAMES(2)
    ) dut (
        .Clock_25(clk),
        .Reset(rst_n),
        .vid(vif)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        h;
        logic        v;
        int unsigned px;
        int unsigned ly;
        logic        err;
    } vec_t;

    vec_t tbl[11];

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One pixel clock of the reference generator; outputs sampled 1ns after the edge.
    task automatic tick();
        logic hs, vs;
        hs = !(gen_px >= HS0 && gen_px < HS1);
        if (glitch && gen_px == HS1) begin
            hs = 1'b0;
            glitch = 1'b0;
        end
        vs = !(gen_ly >= VS0 && gen_ly < VS1);
        if (hold) begin
            hs = 1'b1;
            vs = 1'b1;
        end
        vfall_now = vs_last && !vs;
        vs_last = vs;
        vif.h_synch = hs;
        vif.v_synch = vs;
        @(posedge clk);
        if (gen_px == htot - 1) begin
            gen_px = 0;
            gen_ly = (gen_ly == VT - 1) ? 0 : gen_ly + 1;
        end else begin
            gen_px++;
        end
        cyc++;
        #1;
    endtask

    task automatic do_reset();
        vif.h_synch = 1'b1;
        vif.v_synch = 1'b1;
        rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        gen_px = 0;
        gen_ly = 0;
        vs_last = 1'b1;
        glitch = 1'b0;
        hold = 1'b0;
    endtask

    task automatic relock(input string name);
        int unsigned t_entry = 0;
        bit seen = 0, got = 0;
        for (int i = 0; i < 3 * FRAME + 50; i++) begin
            tick();
            if (vfall_now && !seen) begin
                seen = 1;
                t_entry = cyc;
            end
            if (vif.locked) begin
                got = 1;
                break;
            end
        end
        check(name, (got && seen) ? cyc - t_entry : 0, 2 * FRAME);
    endtask

    task automatic frame_check(input string tag);
        int unsigned mism = 0, de_n = 0, fs_n = 0;
        for (int i = 0; i < FRAME; i++) begin
            tick();
            if (vif.pixel_x != gen_px || vif.line_y != gen_ly || !vif.locked || vif.sync_error ||
                vif.de != (gen_px < W && gen_ly < H))
                mism++;
            if (vif.de) de_n++;
            if (vif.frame_start) fs_n++;
        end
        check({tag, "_track_mismatches"}, mism, 0);
        check({tag, "_de_count"}, de_n, W * H);
        check({tag, "_frame_start_count"}, fs_n, 1);
    endtask

    task automatic wait_gen(input int unsigned px, input int unsigned ly, input string name);
        bit found = 0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            if (gen_px == px && gen_ly == ly) begin
                found = 1;
                break;
            end
            tick();
        end
        if (!found) check({name, "_wait_timeout"}, 0, 1);
    endtask

    initial begin
        // {h, v, pixel_x, line_y, sync_error} after the edge; mode realigns to px 11, line 7
        tbl[0]  = '{1'b1, 1'b1,  1, 0, 1'b0};
        tbl[1]  = '{1'b1, 1'b1,  2, 0, 1'b0};
        tbl[2]  = '{1'b0, 1'b0, 11, 7, 1'b0};  // simultaneous h_fall and v_fall
        tbl[3]  = '{1'b0, 1'b0, 12, 7, 1'b0};
        tbl[4]  = '{1'b0, 1'b1, 13, 7, 1'b1};  // v_rise after 0 lines low: bad V_SYNC
        tbl[5]  = '{1'b1, 1'b1, 14, 7, 1'b0};
        tbl[6]  = '{1'b1, 1'b1, 15, 7, 1'b0};
        tbl[7]  = '{1'b1, 1'b1,  0, 8, 1'b0};  // wrap
        tbl[8]  = '{1'b1, 1'b1,  1, 8, 1'b0};
        tbl[9]  = '{1'b0, 1'b1, 11, 8, 1'b0};
        tbl[10] = '{1'b1, 1'b1, 12, 8, 1'b0};

        do_reset();
        check("reset_pixel_x", vif.pixel_x, 0);
        check("reset_line_y", vif.line_y, 0);
        check("reset_locked", vif.locked, 0);
        check("reset_sync_error", vif.sync_error, 0);
        check("reset_h_period", vif.h_period, 0);

        for (int i = 0; i < 11; i++) begin
            vif.h_synch = tbl[i].h;
            vif.v_synch = tbl[i].v;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_pixel_x", i), vif.pixel_x, tbl[i].px);
            check($sformatf("vec%0d_line_y", i), vif.line_y, tbl[i].ly);
            check($sformatf("vec%0d_sync_error", i), vif.sync_error, tbl[i].err);
            check($sformatf("vec%0d_locked", i), vif.locked, 0);
        end

        // Loopback: lock 2 frames after the first registered v_fall, then track.
        do_reset();
        relock("first_lock_latency");
        check("h_period", vif.h_period, HT);
        check("v_period", vif.v_period, VT);
        frame_check("lock1");

        // One extra low clock at the end of the h pulse.
        wait_gen(HS1, 2, "glitch");
        glitch = 1'b1;
        tick();
        check("glitch_pre_err", vif.sync_error, 0);
        check("glitch_pre_locked", vif.locked, 1);
        tick();
        check("glitch_err", vif.sync_error, 1);
        check("glitch_locked_drop", vif.locked, 0);
        tick();
        check("glitch_err_width", vif.sync_error, 0);
        relock("glitch_relock_latency");

        // Signal loss: h_cnt is 3 after the pulse; 29 more high clocks reach 2*HT.
        wait_gen(HS1 + 1, 1, "loss");
        hold = 1'b1;
        for (int i = 0; i < 28; i++) tick();
        check("loss_pre_err", vif.sync_error, 0);
        check("loss_pre_locked", vif.locked, 1);
        tick();
        check("loss_err", vif.sync_error, 1);
        check("loss_locked_drop", vif.locked, 0);
        tick();
        hold = 1'b0;
        check("loss_err_width", vif.sync_error, 0);
        relock("loss_relock_latency");

        // Asynchronous reset mid-line while locked.
        wait_gen(5, 3, "areset");
        check("areset_was_locked", vif.locked, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("areset_pixel_x", vif.pixel_x, 0);
        check("areset_line_y", vif.line_y, 0);
        check("areset_locked", vif.locked, 0);
        check("areset_de", vif.de, 0);
        check("areset_frame_start", vif.frame_start, 0);
        check("areset_h_period", vif.h_period, 0);
        check("areset_v_period", vif.v_period, 0);
        rst_n = 1'b1;
        gen_px = 0;
        gen_ly = 0;
        vs_last = 1'b1;
        relock("areset_relock_latency");
        frame_check("lock2");

        // Source with one extra clock per line: one error per MEASURE attempt, never locks.
        htot = HT + 1;
        do_reset();
        begin
            int unsigned errs = 0, lk = 0;
            for (int i = 0; i < 4 * (HT + 1) * VT; i++) begin
                tick();
                if (vif.sync_error) errs++;
                if (vif.locked) lk++;
            end
            check("long_line_errors", errs, 4);
            check("long_line_locked_cycles", lk, 0);
            check("long_line_h_period", vif.h_period, HT + 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
